// File: rtl/aes_sha3_pkg.sv
// Shared types and constants for the AES/SHA3 sequencer: state encoding,
// operand byte lengths, mode encoding and a saturating byte-counter helper.
package aes_sha3_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_KEY,
        ST_KDF,
        ST_WAIT_MSG,
        ST_LD_MSG,
        ST_AES,
        ST_OUT_C,
        ST_GAP,
        ST_OUT_M
    } ctrl_state_e;

    typedef enum logic {
        MODE_0 = 1'b0,
        MODE_1 = 1'b1
    } mode_e;

    localparam int SALT_BYTES = 16;
    localparam int PW_BYTES   = 15;
    localparam int MSG_BYTES  = 16;
    localparam int MAC_BYTES  = 32;

    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
        return (v >= lim) ? lim : v + 5'd1;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Loadable shift register that emits a word one byte per cycle, LSB first,
// with a registered valid and a count of bytes still to be shown.
module byte_serializer #(
    parameter int W  = 256,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_bytes,
    output logic [7:0]    o_data,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = load_bytes;
        end else if (cnt_q != '0) begin
            // Shifting past the last byte leaves zeros, so o_data idles at 0.
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q - CW'(1);
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = shift_q[7:0];
    assign o_valid = valid_q;
    assign o_count = cnt_q;

endmodule

// File: rtl/aes_sha3_ctrl.sv
// Sequencer: loads salt/password/message bytes, launches KDF, AES and HMAC
// cores in turn, then streams the cipher and MAC out through one serializer.
module aes_sha3_ctrl #(
    parameter int SALT_BYTES = aes_sha3_pkg::SALT_BYTES,
    parameter int PW_BYTES   = aes_sha3_pkg::PW_BYTES,
    parameter int MSG_BYTES  = aes_sha3_pkg::MSG_BYTES,
    parameter int MAC_BYTES  = aes_sha3_pkg::MAC_BYTES,
    parameter int GAP_CYC    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [7:0]               i_data,
    input  logic                     i_mode,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    output logic                     o_ien,
    output logic                     o_mode,
    output logic [8*SALT_BYTES-1:0]  o_salt,
    output logic [8*PW_BYTES-1:0]    o_pw,
    output logic [8*MSG_BYTES-1:0]   o_msg,
    output logic                     o_kdf_start,
    output logic                     o_aes_start,
    output logic                     o_mac_start,
    input  logic                     i_kdf_done,
    input  logic                     i_aes_done,
    input  logic                     i_mac_done,
    input  logic [8*MSG_BYTES-1:0]   i_cipher,
    input  logic [8*MAC_BYTES-1:0]   i_mac
);
    import aes_sha3_pkg::*;

    localparam int SALT_W = 8 * SALT_BYTES;
    localparam int PW_W   = 8 * PW_BYTES;
    localparam int MSG_W  = 8 * MSG_BYTES;
    localparam int MAC_W  = 8 * MAC_BYTES;
    localparam int CW     = $clog2(MAC_BYTES + 1);
    localparam logic [4:0] KEY_LAST = 5'(SALT_BYTES + PW_BYTES - 1);
    localparam logic [4:0] MSG_LAST = 5'(MSG_BYTES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    ctrl_state_e       state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        gap_q, gap_d;
    logic [SALT_W-1:0] salt_q, salt_d;
    logic [PW_W-1:0]   pw_q, pw_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    mode_e             mode_q, mode_d;
    logic [MAC_W-1:0]  mac_q, mac_d;
    logic              mac_flag_q, mac_flag_d;
    logic              kdf_start_q, kdf_start_d;
    logic              aes_start_q, aes_start_d;
    logic              mac_start_q, mac_start_d;
    logic              ien_q, ien_d;

    logic              ser_load;
    logic [MAC_W-1:0]  ser_data;
    logic [CW-1:0]     ser_bytes;
    logic [CW-1:0]     ser_count;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        salt_d      = salt_q;
        pw_d        = pw_q;
        msg_d       = msg_q;
        mode_d      = mode_q;
        mac_d       = mac_q;
        mac_flag_d  = mac_flag_q;
        kdf_start_d = 1'b0;
        aes_start_d = 1'b0;
        mac_start_d = 1'b0;
        ser_load    = 1'b0;
        ser_data    = '0;
        ser_bytes   = '0;

        // The HMAC core may finish any time after launch; remember it.
        if (i_mac_done && (state_q inside {ST_OUT_C, ST_GAP, ST_OUT_M})) begin
            mac_flag_d = 1'b1;
            mac_d      = i_mac;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    salt_d[SALT_W-1 -: 8] = i_data;
                    mode_d  = mode_e'(i_mode);
                    cnt_d   = 5'd1;
                    state_d = ST_LD_KEY;
                end
            end
            ST_LD_KEY: begin
                if (!i_start) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    for (int b = 1; b < SALT_BYTES; b++)
                        if (cnt_q == 5'(b)) salt_d[SALT_W-1-8*b -: 8] = i_data;
                    for (int b = 0; b < PW_BYTES; b++)
                        if (cnt_q == 5'(SALT_BYTES + b)) pw_d[PW_W-1-8*b -: 8] = i_data;
                    if (cnt_q == KEY_LAST) begin
                        kdf_start_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_KDF;
                    end else begin
                        cnt_d = sat_inc(cnt_q, KEY_LAST);
                    end
                end
            end
            ST_KDF: begin
                if (i_kdf_done) state_d = ST_WAIT_MSG;
            end
            ST_WAIT_MSG: begin
                if (i_start) begin
                    msg_d[MSG_W-1 -: 8] = i_data;
                    cnt_d   = 5'd1;
                    state_d = ST_LD_MSG;
                end
            end
            ST_LD_MSG: begin
                if (!i_start) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_MSG;
                end else begin
                    for (int b = 1; b < MSG_BYTES; b++)
                        if (cnt_q == 5'(b)) msg_d[MSG_W-1-8*b -: 8] = i_data;
                    if (cnt_q == MSG_LAST) begin
                        aes_start_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_AES;
                    end else begin
                        cnt_d = sat_inc(cnt_q, MSG_LAST);
                    end
                end
            end
            ST_AES: begin
                if (i_aes_done) begin
                    ser_load    = 1'b1;
                    ser_data    = {{(MAC_W-MSG_W){1'b0}}, i_cipher};
                    ser_bytes   = CW'(MSG_BYTES);
                    mac_start_d = 1'b1;
                    state_d     = ST_OUT_C;
                end
            end
            ST_OUT_C: begin
                if (ser_count == CW'(1)) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q < GAP_LAST) begin
                    gap_d = gap_q + 8'd1;
                end else if (mac_flag_q || i_mac_done) begin
                    // Forward a same-cycle done so a late MAC starts next cycle.
                    ser_load  = 1'b1;
                    ser_data  = i_mac_done ? i_mac : mac_q;
                    ser_bytes = CW'(MAC_BYTES);
                    state_d   = ST_OUT_M;
                end
            end
            ST_OUT_M: begin
                if (ser_count == CW'(1)) begin
                    mac_flag_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ien_d = !(state_d inside {ST_IDLE, ST_WAIT_MSG});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            salt_q      <= '0;
            pw_q        <= '0;
            msg_q       <= '0;
            mode_q      <= MODE_0;
            mac_q       <= '0;
            mac_flag_q  <= 1'b0;
            kdf_start_q <= 1'b0;
            aes_start_q <= 1'b0;
            mac_start_q <= 1'b0;
            ien_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            salt_q      <= salt_d;
            pw_q        <= pw_d;
            msg_q       <= msg_d;
            mode_q      <= mode_d;
            mac_q       <= mac_d;
            mac_flag_q  <= mac_flag_d;
            kdf_start_q <= kdf_start_d;
            aes_start_q <= aes_start_d;
            mac_start_q <= mac_start_d;
            ien_q       <= ien_d;
        end
    end

    byte_serializer #(
        .W  (MAC_W),
        .CW (CW)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .load_data  (ser_data),
        .load_bytes (ser_bytes),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_count    (ser_count)
    );

    assign o_ien       = ien_q;
    assign o_mode      = mode_q;
    assign o_salt      = salt_q;
    assign o_pw        = pw_q;
    assign o_msg       = msg_q;
    assign o_kdf_start = kdf_start_q;
    assign o_aes_start = aes_start_q;
    assign o_mac_start = mac_start_q;

endmodule

// File: tb/tb_aes_sha3_ctrl.sv
// Bench for aes_sha3_ctrl: emulates the KDF/AES/HMAC cores and predicts the
// output byte stream (values and cycle positions) from the protocol rules.
module tb_aes_sha3_ctrl;

    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start, i_mode;
    logic [7:0]   i_data;
    logic [7:0]   o_data;
    logic         o_valid, o_ien, o_mode;
    logic [127:0] o_salt, o_msg;
    logic [119:0] o_pw;
    logic         o_kdf_start, o_aes_start, o_mac_start;
    logic         i_kdf_done, i_aes_done, i_mac_done;
    logic [127:0] i_cipher;
    logic [255:0] i_mac;

    aes_sha3_ctrl #(.GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data), .i_mode(i_mode),
        .o_data(o_data), .o_valid(o_valid), .o_ien(o_ien), .o_mode(o_mode),
        .o_salt(o_salt), .o_pw(o_pw), .o_msg(o_msg),
        .o_kdf_start(o_kdf_start), .o_aes_start(o_aes_start), .o_mac_start(o_mac_start),
        .i_kdf_done(i_kdf_done), .i_aes_done(i_aes_done), .i_mac_done(i_mac_done),
        .i_cipher(i_cipher), .i_mac(i_mac)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int kdf_n = 0, aes_n = 0, mac_n = 0;
    int kdf_at = 0, aes_at = 0, mac_at = 0;
    int         out_c[$];
    logic [7:0] out_d[$];

    logic [7:0]   key_b[0:30];
    logic [7:0]   msg_b[0:15];
    logic [127:0] cipher;
    logic [255:0] mac;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            out_c.push_back(cyc);
            out_d.push_back(o_data);
        end
        if (o_kdf_start) begin kdf_n++; kdf_at = cyc; end
        if (o_aes_start) begin aes_n++; aes_at = cyc; end
        if (o_mac_start) begin mac_n++; mac_at = cyc; end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
        else $display("ok   %s = %0h", tag, got);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_salt();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], key_b[i]};
        return v;
    endfunction

    function automatic logic [119:0] exp_pw();
        logic [119:0] v = '0;
        for (int i = 0; i < 15; i++) v = {v[111:0], key_b[16+i]};
        return v;
    endfunction

    function automatic logic [127:0] exp_msg();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], msg_b[i]};
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_ien"}, o_ien, 0);
        check({tag, "_mode"}, o_mode, 0);
        check({tag, "_opnd"}, {o_salt, o_pw} | o_msg, 0);
        check({tag, "_starts"}, {o_kdf_start, o_aes_start, o_mac_start}, 0);
    endtask

    task automatic randomize_op();
        for (int i = 0; i < 31; i++) key_b[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) msg_b[i] = 8'($urandom);
        cipher = {$urandom, $urandom, $urandom, $urandom};
        mac    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // One complete transaction; mac_delay is cycles from the aes_done cycle to mac_done.
    task automatic run_op(input logic mode, input int mac_delay, input bit msg_abort,
                          input bit spurious, input int rst_at);
        int k0, a0, m0, last, d, t, ms, ec;
        logic [7:0] eb;
        out_c.delete();
        out_d.delete();
        k0 = kdf_n; a0 = aes_n; m0 = mac_n;
        for (int i = 0; i < 31; i++) begin
            i_start = 1'b1;
            i_data  = key_b[i];
            i_mode  = (i == 0) ? mode : ~mode;
            last    = cyc;
            tick();
        end
        i_start = 1'b0;
        i_data  = 8'($urandom);
        t = 0;
        while (kdf_n == k0 && t < 20) begin tick(); t++; end
        check("kdf_pulses", kdf_n - k0, 1);
        check("kdf_at", kdf_at, last + 1);
        check("salt", o_salt, exp_salt());
        check("pw", o_pw, exp_pw());
        check("mode", o_mode, mode);
        check("ien_kdf", o_ien, 1);
        repeat ($urandom_range(0, 4)) tick();
        i_kdf_done = 1'b1;
        tick();
        i_kdf_done = 1'b0;
        check("ien_wait_msg", o_ien, 0);
        repeat ($urandom_range(0, 3)) tick();
        if (msg_abort) begin
            for (int i = 0; i < 8; i++) begin
                i_start = 1'b1; i_data = 8'($urandom); tick();
            end
            i_start = 1'b0;
            repeat (4) tick();
            check("msg_abort_aes", aes_n - a0, 0);
            check("msg_abort_ien", o_ien, 0);
        end
        for (int i = 0; i < 16; i++) begin
            i_start = 1'b1; i_data = msg_b[i]; last = cyc; tick();
        end
        i_start = 1'b0;
        t = 0;
        while (aes_n == a0 && t < 20) begin tick(); t++; end
        check("aes_pulses", aes_n - a0, 1);
        check("aes_at", aes_at, last + 1);
        check("msg", o_msg, exp_msg());
        if (spurious) begin
            for (int i = 0; i < 3; i++) begin
                i_start = 1'b1; i_data = 8'($urandom); tick();
            end
            i_start = 1'b0;
            check("msg_after_spur", o_msg, exp_msg());
        end
        repeat ($urandom_range(0, 3)) tick();
        i_cipher   = cipher;
        i_aes_done = 1'b1;
        d = cyc;
        tick();
        i_aes_done = 1'b0;
        i_cipher   = ~cipher;
        t = 0;
        while (out_d.size() < 48 && t < 150) begin
            if (rst_at >= 0 && out_d.size() == 16 + rst_at) break;
            if (cyc == d + mac_delay) begin i_mac = mac; i_mac_done = 1'b1; end
            if (spurious && cyc == d + 4) i_kdf_done = 1'b1;
            tick();
            i_mac_done = 1'b0;
            i_kdf_done = 1'b0;
            i_mac      = ~mac;
            t++;
        end
        check("mac_pulses", mac_n - m0, 1);
        check("mac_at", mac_at, d + 1);
        if (rst_at >= 0) begin
            check("pre_reset_valid", o_valid, 1);
            rst_n = 1'b0;
            #1;
            check_all_zero("rst_now");
            tick();
            tick();
            check_all_zero("rst_hold");
            rst_n = 1'b1;
            tick();
            return;
        end
        check("n_bytes", out_d.size(), 48);
        check("kdf_total", kdf_n - k0, 1);
        check("aes_total", aes_n - a0, 1);
        ms = (d + mac_delay + 1 > d + 17 + GAP) ? d + mac_delay + 1 : d + 17 + GAP;
        for (int k = 0; k < 48 && k < out_d.size(); k++) begin
            if (k < 16) begin
                ec = d + 1 + k;
                eb = 8'(cipher >> (8 * k));
            end else begin
                ec = ms + (k - 16);
                eb = 8'(mac >> (8 * (k - 16)));
            end
            check($sformatf("%s%0d@cyc,byte", (k < 16) ? "ct" : "mac", (k < 16) ? k : k - 16),
                  {out_c[k], out_d[k]}, {ec, eb});
        end
        check("ien_idle", o_ien, 0);
        check("valid_idle", o_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_data = '0; i_mode = 1'b0;
        i_kdf_done = 1'b0; i_aes_done = 1'b0; i_mac_done = 1'b0;
        i_cipher = '0; i_mac = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Full pass with the patterned operands; MAC finishes during the cipher burst.
        for (int i = 0; i < 31; i++) key_b[i] = 8'(i);
        for (int i = 0; i < 16; i++) msg_b[i] = 8'(8'h20 + i);
        cipher = {$urandom, $urandom, $urandom, $urandom};
        mac    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_op(1'b0, 5, 1'b0, 1'b0, -1);
        check("salt_pattern", o_salt, 128'h000102030405060708090a0b0c0d0e0f);

        // Key load aborted after 20 bytes.
        begin
            int k0;
            k0 = kdf_n;
            for (int i = 0; i < 20; i++) begin
                i_start = 1'b1; i_data = 8'($urandom); i_mode = 1'b0; tick();
                if (i == 3) check("ien_loading", o_ien, 1);
            end
            i_start = 1'b0;
            repeat (4) tick();
            check("key_abort_kdf", kdf_n - k0, 0);
            check("key_abort_ien", o_ien, 0);
        end

        // MAC done in the gap, with an aborted message load first.
        randomize_op();
        run_op(1'($urandom), 17, 1'b1, 1'b0, -1);

        // Late MAC plus spurious i_start in AES and kdf_done in OUT_C.
        randomize_op();
        run_op(1'b0, 50, 1'b0, 1'b1, -1);

        // Reset while MAC byte 10 is on the output, then a fresh mode-1 run.
        randomize_op();
        run_op(1'b0, 6, 1'b0, 1'b0, 10);
        randomize_op();
        run_op(1'b1, 3, 1'b0, 1'b0, -1);

        for (int r = 0; r < 3; r++) begin
            randomize_op();
            run_op(1'($urandom), int'($urandom_range(2, 60)), 1'($urandom), 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
